// File: rtl/mont_pkg.sv
// Shared constants for the Montgomery constant scheduler: datapath width, FSM encodings, requester ids.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mont_pkg;

    // Modulus and constant width in bits.
    localparam int DATA_LENGTH = 1024;

    // Controller states. Plain 3-bit constants keep the encoding visible to older tools.
    localparam logic [2:0] ST_DRAIN  = 3'd0;
    localparam logic [2:0] ST_IDLE   = 3'd1;
    localparam logic [2:0] ST_CHECK  = 3'd2;
    localparam logic [2:0] ST_LAUNCH = 3'd3;
    localparam logic [2:0] ST_WAIT   = 3'd4;
    localparam logic [2:0] ST_RESP   = 3'd5;

    // Requester identifiers, as carried on rsp_id.
    localparam logic REQ_ID_0 = 1'b0;
    localparam logic REQ_ID_1 = 1'b1;

endpackage

// File: rtl/mont_const_sched_if.sv
// Bundle of requester, response, cache-flush and engine signals around the constant scheduler.
// Latency: none (wiring only).
// Backpressure: requests are levels held until their ack; ready shows when a new grant can happen.
interface mont_const_sched_if #(
    parameter int DW = mont_pkg::DATA_LENGTH
);
    // Requester side
    logic          req_0;
    logic [DW-1:0] mod_0;
    logic          req_1;
    logic [DW-1:0] mod_1;
    logic          ack_0;
    logic          ack_1;
    logic          rsp_id;
    logic          rsp_err;
    logic [DW-1:0] rsp_R_r;
    logic [DW-1:0] rsp_R_t;
    logic          flush;
    logic          ready;

    // Engine side
    logic          eng_start;
    logic [DW-1:0] eng_M;
    logic          eng_done;
    logic [DW-1:0] eng_R_r;
    logic [DW-1:0] eng_R_t;

    // Scheduler view
    modport slave (
        input  req_0, mod_0, req_1, mod_1, flush, eng_done, eng_R_r, eng_R_t,
        output ack_0, ack_1, rsp_id, rsp_err, rsp_R_r, rsp_R_t, ready, eng_start, eng_M
    );

    // Environment view: requesters plus the engine
    modport master (
        output req_0, mod_0, req_1, mod_1, flush, eng_done, eng_R_r, eng_R_t,
        input  ack_0, ack_1, rsp_id, rsp_err, rsp_R_r, rsp_R_t, ready, eng_start, eng_M
    );

endinterface

// File: rtl/mont_const_cache.sv
// One-entry cache of the last computed (modulus, R mod N, R^2 mod N) triple with compare, write and invalidate.
// Latency: hit is combinational from the lookup modulus; writes and invalidates land on the next clock.
// Backpressure: none; a write and an invalidate in the same cycle leave the entry invalid.
module mont_const_cache
    import mont_pkg::*;
#(
    parameter int DW = DATA_LENGTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] lookup_mod,
    output logic          hit,
    output logic [DW-1:0] hit_r,
    output logic [DW-1:0] hit_t,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_mod,
    input  logic [DW-1:0] wr_r,
    input  logic [DW-1:0] wr_t,
    input  logic          inv
);

    logic          vld_q, vld_d;
    logic [DW-1:0] tag_q, tag_d;
    logic [DW-1:0] r_q, r_d;
    logic [DW-1:0] t_q, t_d;

    // Lookup: an invalidate in the same cycle forces a miss.
    always_comb begin
        hit   = vld_q && !inv && (tag_q == lookup_mod);
        hit_r = r_q;
        hit_t = t_q;
    end

    // Next entry: write installs a new triple, invalidate always has the last word on valid.
    always_comb begin
        vld_d = vld_q;
        tag_d = tag_q;
        r_d   = r_q;
        t_d   = t_q;
        if (wr_en) begin
            vld_d = 1'b1;
            tag_d = wr_mod;
            r_d   = wr_r;
            t_d   = wr_t;
        end
        if (inv) begin
            vld_d = 1'b0;
        end
    end

    // Entry registers, cleared on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            tag_q <= '0;
            r_q   <= '0;
            t_q   <= '0;
        end else begin
            vld_q <= vld_d;
            tag_q <= tag_d;
            r_q   <= r_d;
            t_q   <= t_d;
        end
    end

endmodule

// File: rtl/mont_const_sched.sv
// Montgomery constant scheduler: round-robin grant of two requesters, one-entry result cache, engine launch with timeout.
// Latency: 2 cycles from IDLE sample to ack on a cache hit or even modulus; engine done + 1 on a miss.
// Backpressure: requests are held levels; ready is low outside IDLE, so a pending request simply waits.
module mont_const_sched
    import mont_pkg::*;
#(
    parameter int DATA_LENGTH = mont_pkg::DATA_LENGTH,
    parameter int TIMEOUT_CYC = 4096,
    parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    mont_const_sched_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [2:0]             state_q, state_d;
    logic                   ptr_q, ptr_d;
    logic                   id_q, id_d;
    logic [DATA_LENGTH-1:0] mod_q, mod_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   to_q, to_d;
    logic [DATA_LENGTH-1:0] res_r_q, res_r_d;
    logic [DATA_LENGTH-1:0] res_t_q, res_t_d;

    logic                   grant_1;
    logic                   cache_hit;
    logic [DATA_LENGTH-1:0] cache_r;
    logic [DATA_LENGTH-1:0] cache_t;
    logic                   cache_wr;
    logic                   cache_inv;

    mont_const_cache #(
        .DW (DATA_LENGTH)
    ) u_cache (
        .clk        (clk),
        .rst_n      (rst_n),
        .lookup_mod (mod_q),
        .hit        (cache_hit),
        .hit_r      (cache_r),
        .hit_t      (cache_t),
        .wr_en      (cache_wr),
        .wr_mod     (mod_q),
        .wr_r       (bus.eng_R_r),
        .wr_t       (bus.eng_R_t),
        .inv        (cache_inv)
    );

    // Round-robin pick: requester 1 wins alone, or when both ask and the pointer favours it.
    always_comb begin
        grant_1 = bus.req_1 && (!bus.req_0 || (ptr_q == REQ_ID_1));
    end

    // Controller next state. Results and err only change on the transition into RESP,
    // so the response fields stay stable from one ack to the next.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        mod_d     = mod_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        to_d      = to_q;
        res_r_d   = res_r_q;
        res_t_d   = res_t_q;
        cache_wr  = 1'b0;
        cache_inv = bus.flush;

        case (state_q)
            // The engine has no reset; wait out any computation still in flight.
            ST_DRAIN: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_IDLE: begin
                if (bus.req_0 || bus.req_1) begin
                    id_d    = grant_1 ? REQ_ID_1 : REQ_ID_0;
                    mod_d   = grant_1 ? bus.mod_1 : bus.mod_0;
                    ptr_d   = grant_1 ? REQ_ID_0 : REQ_ID_1;
                    state_d = ST_CHECK;
                end
            end

            // Even (including zero) moduli have no Montgomery form: reject without the engine.
            ST_CHECK: begin
                if (!mod_q[0]) begin
                    err_d   = 1'b1;
                    to_d    = 1'b0;
                    res_r_d = '0;
                    res_t_d = '0;
                    state_d = ST_RESP;
                end else if (cache_hit) begin
                    err_d   = 1'b0;
                    to_d    = 1'b0;
                    res_r_d = cache_r;
                    res_t_d = cache_t;
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_LAUNCH;
                end
            end

            ST_LAUNCH: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end

            // Done takes priority over a timeout landing in the same cycle.
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_ONE;
                if (bus.eng_done) begin
                    err_d    = 1'b0;
                    to_d     = 1'b0;
                    res_r_d  = bus.eng_R_r;
                    res_t_d  = bus.eng_R_t;
                    cache_wr = 1'b1;
                    state_d  = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    err_d     = 1'b1;
                    to_d      = 1'b1;
                    res_r_d   = '0;
                    res_t_d   = '0;
                    cache_inv = 1'b1;
                    state_d   = ST_RESP;
                end
            end

            // After a timeout the engine may still answer late, so drain before serving again.
            ST_RESP: begin
                if (to_q) begin
                    to_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_DRAIN;
            end
        endcase
    end

    // Controller registers; reset enters DRAIN with the pointer on requester 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_DRAIN;
            ptr_q   <= REQ_ID_0;
            id_q    <= REQ_ID_0;
            mod_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
            res_r_q <= '0;
            res_t_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            mod_q   <= mod_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            to_q    <= to_d;
            res_r_q <= res_r_d;
            res_t_q <= res_t_d;
        end
    end

    // Outputs decoded from registered state; eng_M is only presented while the engine owns it.
    always_comb begin
        bus.ready     = (state_q == ST_IDLE);
        bus.eng_start = (state_q == ST_LAUNCH);
        bus.eng_M     = ((state_q == ST_LAUNCH) || (state_q == ST_WAIT)) ? mod_q : '0;
        bus.ack_0     = (state_q == ST_RESP) && (id_q == REQ_ID_0);
        bus.ack_1     = (state_q == ST_RESP) && (id_q == REQ_ID_1);
        bus.rsp_id    = id_q;
        bus.rsp_err   = err_q;
        bus.rsp_R_r   = res_r_q;
        bus.rsp_R_t   = res_t_q;
    end

endmodule
